// File: rtl/weight_rom_stream_ctrl.sv
`default_nettype none
// ============================================================================
// weight_rom_stream_ctrl: streams N passes of a latency-ROM into a ready/valid
// consumer through a credit-controlled skid FIFO.   Revision: 1.0
// ============================================================================
module weight_rom_stream_ctrl #(
  parameter int DATA_WIDTH  = 128,
  parameter int DEPTH       = 2304,
  parameter int ADDR_WIDTH  = $clog2(DEPTH) + 1,
  parameter int ROM_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int PASS_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [PASS_WIDTH-1:0] pass_count,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] rom_address0,
  output logic                  rom_ce0,
  input  logic [DATA_WIDTH-1:0] rom_q0,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1) + 1;
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [c_PTR_W-1:0]    c_PTR_LAST  = c_PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [PASS_WIDTH-1:0]  r_pass;
  logic [PASS_WIDTH-1:0]  r_pass_target;
  logic [ROM_LATENCY-1:0] r_inflight;
  logic [DATA_WIDTH-1:0]  r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]     r_wr_ptr;
  logic [c_PTR_W-1:0]     r_rd_ptr;
  logic [c_CNT_W-1:0]     r_count;
  logic [c_CNT_W-1:0]     w_inflight_cnt;
  logic                   r_done;
  logic                   w_done_next;
  logic                   w_issue;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_last_issue;
  logic                   w_drain_done;

  if (FIFO_DEPTH < ROM_LATENCY + 1) begin : g_bad_fifo_depth
    $error("FIFO_DEPTH must be at least ROM_LATENCY+1");
  end

  always_comb begin
    w_inflight_cnt = '0;
    for (int i = 0; i < ROM_LATENCY; i++) begin
      w_inflight_cnt = w_inflight_cnt + c_CNT_W'(r_inflight[i]);
    end
  end

  // Credit counts every word already owed to the FIFO, so a push can never overflow.
  assign w_issue      = (r_state == S_RUN) &&
                        ((r_count + w_inflight_cnt) < c_CNT_W'(FIFO_DEPTH));
  assign w_push       = r_inflight[ROM_LATENCY-1];
  assign w_pop        = (r_count != '0) && data_out_ready;
  assign w_last_issue = w_issue && (r_addr == c_ADDR_LAST) &&
                        (r_pass == r_pass_target - PASS_WIDTH'(1));
  // Leave DRAIN on the edge that pops the final word.
  assign w_drain_done = (w_inflight_cnt == '0) &&
                        ((r_count == '0) || ((r_count == c_CNT_W'(1)) && w_pop));

  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (pass_count != '0) begin
            w_state_next = S_RUN;
          end else begin
            w_done_next = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (w_last_issue) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_drain_done) begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else if (abort) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_done_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr        <= '0;
      r_pass        <= '0;
      r_pass_target <= '0;
      r_inflight    <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
    end else if (abort) begin
      r_addr     <= '0;
      r_pass     <= '0;
      r_inflight <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_addr        <= '0;
        r_pass        <= '0;
        r_pass_target <= pass_count;
      end else if (w_issue) begin
        if (r_addr == c_ADDR_LAST) begin
          r_addr <= '0;
          r_pass <= r_pass + PASS_WIDTH'(1);
        end else begin
          r_addr <= r_addr + ADDR_WIDTH'(1);
        end
      end

      r_inflight[0] <= w_issue;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        r_inflight[i] <= r_inflight[i-1];
      end

      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PTR_W'(1);
      end

      if (w_push && !w_pop) begin
        r_count <= r_count + c_CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - c_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !abort) begin
      r_mem[r_wr_ptr] <= rom_q0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !abort && w_push && !w_pop) begin
      assert (r_count < c_CNT_W'(FIFO_DEPTH));
    end
  end

  assign rom_ce0        = w_issue;
  assign rom_address0   = r_addr;
  assign data_out_valid = (r_count != '0);
  assign data_out       = data_out_valid ? r_mem[r_rd_ptr] : '0;
  assign busy           = (r_state != S_IDLE);
  assign done           = r_done;

endmodule
`default_nettype wire

// File: doc/weight_rom_stream_ctrl.md
Name: weight_rom_stream_ctrl

Overview:
- Sequencer between a 2-cycle-latency parameter ROM (ce0/address0/q0 interface) and a valid/ready weight consumer.
- Generates ROM addresses for a configurable number of full passes over the ROM.
- Tracks in-flight reads and buffers returned words in a small skid FIFO, so backpressure never loses data and full throughput is kept.
- Replaces the free-running counter/always-valid scheme in weight sources; supports start/done and abort.

Parameters:
- DATA_WIDTH, 128, width of one ROM word / output beat.
- DEPTH, 2304, number of ROM words per pass.
- ADDR_WIDTH, $clog2(DEPTH)+1, ROM address width.
- ROM_LATENCY, 2, cycles from issue (ce0=1) to valid rom_q0; fixed pipeline.
- FIFO_DEPTH, 4, skid FIFO entries; must be >= ROM_LATENCY+1.
- PASS_WIDTH, 16, width of pass_count.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- pass_count  in  PASS_WIDTH  number of full passes; sampled with start.
- abort  in  1  synchronous flush, returns to IDLE.
- rom_address0  out  ADDR_WIDTH  ROM read address.
- rom_ce0  out  1  ROM clock enable / read issue.
- rom_q0  in  DATA_WIDTH  ROM read data, ROM_LATENCY cycles after issue.
- data_out  out  DATA_WIDTH  FIFO head word.
- data_out_valid  out  1  FIFO non-empty.
- data_out_ready  in  1  consumer accept.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on completion.

Behaviour:
- Reset (async) values:
  - state=IDLE, addr=0, pass=0, inflight shift register=0, FIFO empty.
  - rom_ce0=0, rom_address0=0, data_out_valid=0, data_out=0, busy=0, done=0.
- States:
  - IDLE: start=1 with pass_count>0 -> RUN; addr=0, pass=0.
  - IDLE: start=1 with pass_count=0 -> no ROM reads; done pulses next cycle; stay IDLE.
  - RUN: issues reads. After the issue of addr DEPTH-1 on pass pass_count-1 -> DRAIN.
  - DRAIN: no issues. Go to IDLE and pulse done in the cycle after the last beat handshake (FIFO empty and inflight=0).
- Issue rule:
  - In RUN, rom_ce0=1 iff fifo_count + inflight_count < FIFO_DEPTH, using registered counts; no same-cycle pop credit.
  - rom_address0 = addr. On issue, addr increments.
  - addr DEPTH-1 wraps to 0 and pass increments.
  - rom_ce0=0 outside RUN and whenever the credit is exhausted.
- Inflight tracking:
  - A ROM_LATENCY-deep shift register carries issue bits.
  - When the tap exits, rom_q0 is written into the FIFO at that edge.
  - The credit rule guarantees no write ever hits a full FIFO. An overflow is an assertion failure.
- Output handshake:
  - data_out_valid = FIFO non-empty; data_out = head entry.
  - Pop on valid&ready.
  - data_out stays stable while valid=1 and ready=0.
  - Push and pop in the same cycle leave count unchanged.
- Latency:
  - start sampled at edge E0 -> address 0 issued in the cycle after E0.
  - Word 0 is written to the FIFO at E3; data_out_valid rises after E3.
  - With ready held high, one beat per cycle from then on, no bubbles across pass wrap.
- Beat count: total beats = pass_count*DEPTH, in order 0..DEPTH-1 repeated.
- abort (any state): next edge clears the FIFO, inflight bits, addr, and pass, and sets state=IDLE.
  - ROM returns still in the pipe are discarded.
  - done does not pulse.
  - abort has priority over start.
- done and busy:
  - done is high for exactly one cycle. busy falls in the same cycle done rises.
  - start during RUN/DRAIN is ignored.

Test Plan:
- DEPTH=8, pass_count=1, ready=1: start at E0 -> valid from after E3; 8 consecutive beats with data = ROM[0..7]; done one cycle after beat 7; busy low after that.
- DEPTH=8, pass_count=3, ready=1: 24 gapless beats, sequence 0..7 x3; rom_address0 wraps 7->0 with no idle cycle; single done.
- ready toggling 1,0,0,1 pattern, pass_count=2: no drop or duplicate of the 16 beats; data_out stable while stalled; fifo_count never exceeds 4; rom_ce0 drops when the credit is exhausted.
- ready held 0 for 20 cycles after start: exactly 4 reads issued, FIFO full, valid=1 with data=ROM[0]; releasing ready delivers ROM[0..7] in order.
- abort mid-pass (after beat 3 accepted, 2 reads inflight): next cycle valid=0, busy=0, no done; the following start replays from ROM[0].
- pass_count=0 start: no rom_ce0 assertion; done pulses the next cycle; start asserted during RUN is ignored (beat count unchanged).
